// File: rtl/bbus_pkg.sv
// -----------------------------------------------------------------------------
// bbus_pkg
// Shared types and constants for the buffered chip-bus sequencer:
//   - bbus_state_e : access phases IDLE/SETUP/STROBE/HOLD/RECOVER
//   - CHIP_*       : chip-select encoding carried on the request chip field
//   - CNT_W        : width of the per-phase down-counter
//   - CYC_MIN/MAX  : legal range of every phase-length parameter
//   - cyc_load()   : clamps a phase-length parameter into that range
// -----------------------------------------------------------------------------
package bbus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RECOVER = 3'd4
    } bbus_state_e;

    localparam logic CHIP_W5300 = 1'b0;
    localparam logic CHIP_SL811 = 1'b1;

    localparam int CNT_W  = 3;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;

    localparam int CYC_MIN = 1;
    localparam int CYC_MAX = 7;

    // A zero load would wrap the down-counter and stretch the phase to 8 cycles,
    // so out-of-range lengths are pinned to the nearest legal value.
    function automatic logic [CNT_W-1:0] cyc_load(input int cyc);
        if (cyc < CYC_MIN)
            return CNT_W'(CYC_MIN);
        else if (cyc > CYC_MAX)
            return CNT_W'(CYC_MAX);
        else
            return CNT_W'(cyc);
    endfunction

endpackage

// File: rtl/bbus_if.sv
// -----------------------------------------------------------------------------
// bbus_if
// One requester's handshake with the bus sequencer.
//   req   : level request, held until done
//   we    : 1 = write, 0 = read (stable while req)
//   chip  : 0 = W5300, 1 = SL811 (stable while req)
//   addr  : chip address (stable while req)
//   wdata : write data (stable while req)
//   done  : one-cycle completion pulse
//   rdata : read data, valid with done, held until the next read
// Modports: master = requester side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface bbus_if;
    import bbus_pkg::*;

    logic              req;
    logic              we;
    logic              chip;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              done;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, chip, addr, wdata, input done, rdata);
    modport slave  (input req, we, chip, addr, wdata, output done, rdata);

endinterface

// File: rtl/bbus_pick.sv
// -----------------------------------------------------------------------------
// bbus_pick
// Two-way grant picker.
//   req0_i  : request from m0
//   req1_i  : request from m1
//   last1_i : 1 when m1 was the last master granted
//   any_o   : at least one request pending
//   sel_o   : selected master (0 = m0, 1 = m1)
// On a tie the master not served last wins. Holding last1_i at 1 makes this a
// fixed m0-over-m1 priority picker.
// -----------------------------------------------------------------------------
module bbus_pick (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last1_i,
    output logic any_o,
    output logic sel_o
);

    assign any_o = req0_i | req1_i;
    assign sel_o = (req0_i && req1_i) ? ~last1_i : req1_i;

endmodule

// File: rtl/bbus_sequencer.sv
// -----------------------------------------------------------------------------
// bbus_sequencer
// Owns the buffered chip bus to the W5300 and SL811. Two requesters share it
// (m0 = Z80 port/ROM-window path, m1 = internal register poller). Every access
// runs SETUP -> STROBE -> HOLD -> RECOVER with programmable phase lengths.
// Read data is captured on the edge that ends STROBE.
//
// Ports
//   fclk, rst      : clock, asynchronous active-high reset
//   m0, m1         : requester handshakes (bbus_if.slave)
//   w5300_cs_n_o   : W5300 chip select
//   sl811_cs_n_o   : SL811 chip select
//   bus_addr_o     : registered bus address
//   brd_n_o        : read strobe
//   bwr_n_o        : write strobe
//   bd_out_o       : write data to the bd pad
//   bd_oe_o        : bd output enable (writes only)
//   bd_in_i        : bd pad input
//   busy_o         : high in every state except IDLE
//
// Configuration macro
//   BBUS_RR_EN : defined -> round-robin arbitration (m0 wins the first tie);
//                undefined -> fixed priority, m0 over m1.
// -----------------------------------------------------------------------------
module bbus_sequencer
    import bbus_pkg::*;
#(
    parameter int SETUP_CYC   = 1,
    parameter int STROBE_CYC  = 4,
    parameter int HOLD_CYC    = 1,
    parameter int RECOVER_CYC = 1
) (
    input  logic              fclk,
    input  logic              rst,
    bbus_if.slave             m0,
    bbus_if.slave             m1,
    output logic              w5300_cs_n_o,
    output logic              sl811_cs_n_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic              brd_n_o,
    output logic              bwr_n_o,
    output logic [DATA_W-1:0] bd_out_o,
    output logic              bd_oe_o,
    input  logic [DATA_W-1:0] bd_in_i,
    output logic              busy_o
);

    localparam logic [CNT_W-1:0] SETUP_LD   = cyc_load(SETUP_CYC);
    localparam logic [CNT_W-1:0] STROBE_LD  = cyc_load(STROBE_CYC);
    localparam logic [CNT_W-1:0] HOLD_LD    = cyc_load(HOLD_CYC);
    localparam logic [CNT_W-1:0] RECOVER_LD = cyc_load(RECOVER_CYC);

    bbus_state_e       state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              cnt_last;
    logic              sel_q;
    logic              we_q;
    logic              cs0_n_q, cs1_n_q;
    logic [ADDR_W-1:0] addr_q;
    logic              brd_n_q, bwr_n_q;
    logic [DATA_W-1:0] bd_out_q;
    logic              bd_oe_q;
    logic              busy_q;
    logic              done0_q, done1_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    logic              pick_any, pick_sel, last1;
    logic              sel_we, sel_chip;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    bbus_pick u_pick (
        .req0_i  (m0.req),
        .req1_i  (m1.req),
        .last1_i (last1),
        .any_o   (pick_any),
        .sel_o   (pick_sel)
    );

`ifdef BBUS_RR_EN
    // Last-granted master; starts at m1 so m0 wins the first tie.
    logic last1_q;
    always_ff @(posedge fclk or posedge rst) begin
        if (rst)
            last1_q <= 1'b1;
        else if (state_q == ST_IDLE && pick_any)
            last1_q <= pick_sel;
    end
    assign last1 = last1_q;
`else
    assign last1 = 1'b1;
`endif

    always_comb begin
        sel_we    = m0.we;
        sel_chip  = m0.chip;
        sel_addr  = m0.addr;
        sel_wdata = m0.wdata;
        if (pick_sel) begin
            sel_we    = m1.we;
            sel_chip  = m1.chip;
            sel_addr  = m1.addr;
            sel_wdata = m1.wdata;
        end
    end

    assign cnt_d    = cnt_q - 1'b1;
    assign cnt_last = (cnt_q == CNT_W'(1));

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sel_q    <= 1'b0;
            we_q     <= 1'b0;
            cs0_n_q  <= 1'b1;
            cs1_n_q  <= 1'b1;
            addr_q   <= '0;
            brd_n_q  <= 1'b1;
            bwr_n_q  <= 1'b1;
            bd_out_q <= '0;
            bd_oe_q  <= 1'b0;
            busy_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // Grant and put the address/select on the pads in one edge.
                    if (pick_any) begin
                        sel_q   <= pick_sel;
                        we_q    <= sel_we;
                        addr_q  <= sel_addr;
                        cs0_n_q <= (sel_chip != CHIP_W5300);
                        cs1_n_q <= (sel_chip != CHIP_SL811);
                        if (sel_we) begin
                            bd_out_q <= sel_wdata;
                            bd_oe_q  <= 1'b1;
                        end
                        busy_q  <= 1'b1;
                        cnt_q   <= SETUP_LD;
                        state_q <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt_last) begin
                        if (we_q)
                            bwr_n_q <= 1'b0;
                        else
                            brd_n_q <= 1'b0;
                        cnt_q   <= STROBE_LD;
                        state_q <= ST_STROBE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_STROBE: begin
                    if (cnt_last) begin
                        brd_n_q <= 1'b1;
                        bwr_n_q <= 1'b1;
                        // Sample bd while the read strobe is still low.
                        if (!we_q) begin
                            if (sel_q)
                                rdata1_q <= bd_in_i;
                            else
                                rdata0_q <= bd_in_i;
                        end
                        cnt_q   <= HOLD_LD;
                        state_q <= ST_HOLD;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_HOLD: begin
                    if (cnt_last) begin
                        cs0_n_q <= 1'b1;
                        cs1_n_q <= 1'b1;
                        bd_oe_q <= 1'b0;
                        if (sel_q)
                            done1_q <= 1'b1;
                        else
                            done0_q <= 1'b1;
                        cnt_q   <= RECOVER_LD;
                        state_q <= ST_RECOVER;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_RECOVER: begin
                    // Covers the cycle in which the served requester drops req.
                    if (cnt_last) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign m0.done  = done0_q;
    assign m1.done  = done1_q;
    assign m0.rdata = rdata0_q;
    assign m1.rdata = rdata1_q;

    assign w5300_cs_n_o = cs0_n_q;
    assign sl811_cs_n_o = cs1_n_q;
    assign bus_addr_o   = addr_q;
    assign brd_n_o      = brd_n_q;
    assign bwr_n_o      = bwr_n_q;
    assign bd_out_o     = bd_out_q;
    assign bd_oe_o      = bd_oe_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_bbus_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bbus_sequencer
// Directed bench for bbus_sequencer: one instance at default timing (1/4/1/1)
// and one at 2/7/3/2. Cycle counts of pad activity are taken on the falling
// edge; requests are driven just after the rising edge.
// -----------------------------------------------------------------------------
module tb_bbus_sequencer;

    logic       fclk = 1'b0;
    logic       rst  = 1'b1;
    logic [7:0] bd_in = 8'h00;

    always #5 fclk = ~fclk;

    int checks = 0;
    int errors = 0;

    // ---------------- default-timing instance ----------------
    bbus_if a_m0 ();
    bbus_if a_m1 ();
    logic       a_cs0_n, a_cs1_n, a_brd_n, a_bwr_n, a_oe, a_busy;
    logic [9:0] a_addr;
    logic [7:0] a_bd_out;

    bbus_sequencer dut (
        .fclk         (fclk),
        .rst          (rst),
        .m0           (a_m0),
        .m1           (a_m1),
        .w5300_cs_n_o (a_cs0_n),
        .sl811_cs_n_o (a_cs1_n),
        .bus_addr_o   (a_addr),
        .brd_n_o      (a_brd_n),
        .bwr_n_o      (a_bwr_n),
        .bd_out_o     (a_bd_out),
        .bd_oe_o      (a_oe),
        .bd_in_i      (bd_in),
        .busy_o       (a_busy)
    );

    // ---------------- 2/7/3/2 instance ----------------
    bbus_if p_m0 ();
    bbus_if p_m1 ();
    logic       p_cs0_n, p_cs1_n, p_brd_n, p_bwr_n, p_oe, p_busy;
    logic [9:0] p_addr;
    logic [7:0] p_bd_out;

    bbus_sequencer #(
        .SETUP_CYC   (2),
        .STROBE_CYC  (7),
        .HOLD_CYC    (3),
        .RECOVER_CYC (2)
    ) dut_p (
        .fclk         (fclk),
        .rst          (rst),
        .m0           (p_m0),
        .m1           (p_m1),
        .w5300_cs_n_o (p_cs0_n),
        .sl811_cs_n_o (p_cs1_n),
        .bus_addr_o   (p_addr),
        .brd_n_o      (p_brd_n),
        .bwr_n_o      (p_bwr_n),
        .bd_out_o     (p_bd_out),
        .bd_oe_o      (p_oe),
        .bd_in_i      (bd_in),
        .busy_o       (p_busy)
    );

    // ---------------- activity counters ----------------
    int n_cs0, n_cs1, n_rd, n_wr, n_oe, n_d0, n_d1, n_viol, n_bdbad;
    int pn_cs, pn_str;
    logic [7:0] exp_bd = 8'h00;

    always @(negedge fclk) begin
        if (!a_cs0_n) n_cs0++;
        if (!a_cs1_n) n_cs1++;
        if (!a_brd_n) n_rd++;
        if (!a_bwr_n) n_wr++;
        if (a_oe)     n_oe++;
        if (a_m0.done) n_d0++;
        if (a_m1.done) n_d1++;
        if (!a_cs0_n && !a_cs1_n) n_viol++;
        if ((!a_brd_n || !a_bwr_n) && a_cs0_n && a_cs1_n) n_viol++;
        if (a_oe && a_bd_out !== exp_bd) n_bdbad++;
        if (!p_cs0_n || !p_cs1_n) pn_cs++;
        if (!p_brd_n || !p_bwr_n) pn_str++;
    end

    task automatic clear_cnt();
        n_cs0 = 0; n_cs1 = 0; n_rd = 0; n_wr = 0; n_oe = 0;
        n_d0 = 0; n_d1 = 0; n_viol = 0; n_bdbad = 0;
        pn_cs = 0; pn_str = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One access on the default instance; lat = rising edges from req to done seen.
    task automatic a_access(input bit who, input logic we, input logic chip,
                            input logic [9:0] addr, input logic [7:0] wd,
                            output int lat, output logic [7:0] rd);
        lat = 0;
        rd  = 8'hxx;
        if (who) begin
            a_m1.we = we; a_m1.chip = chip; a_m1.addr = addr; a_m1.wdata = wd; a_m1.req = 1'b1;
        end else begin
            a_m0.we = we; a_m0.chip = chip; a_m0.addr = addr; a_m0.wdata = wd; a_m0.req = 1'b1;
        end
        for (int i = 1; i <= 40; i++) begin
            @(posedge fclk); #1;
            if (who ? a_m1.done : a_m0.done) begin
                lat = i;
                rd  = who ? a_m1.rdata : a_m0.rdata;
                break;
            end
        end
        a_m0.req = 1'b0;
        a_m1.req = 1'b0;
    endtask

    task automatic p_access(input logic we, input logic [9:0] addr, input logic [7:0] wd,
                            output int lat);
        lat = 0;
        p_m0.we = we; p_m0.chip = 1'b0; p_m0.addr = addr; p_m0.wdata = wd; p_m0.req = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge fclk); #1;
            if (p_m0.done) begin
                lat = i;
                break;
            end
        end
        p_m0.req = 1'b0;
    endtask

    int         lat, d0cyc, d1cyc;
    logic [7:0] rd;

    initial begin
        a_m0.req = 0; a_m0.we = 0; a_m0.chip = 0; a_m0.addr = '0; a_m0.wdata = '0;
        a_m1.req = 0; a_m1.we = 0; a_m1.chip = 0; a_m1.addr = '0; a_m1.wdata = '0;
        p_m0.req = 0; p_m0.we = 0; p_m0.chip = 0; p_m0.addr = '0; p_m0.wdata = '0;
        p_m1.req = 0; p_m1.we = 0; p_m1.chip = 0; p_m1.addr = '0; p_m1.wdata = '0;
        clear_cnt();
        #22 rst = 1'b0;
        #1;

        // Reset state
        check("rst_ctrl", {a_cs0_n, a_cs1_n, a_brd_n, a_bwr_n, a_oe, a_busy, a_m0.done, a_m1.done},
              8'b1111_0000);
        check("rst_addr", a_addr, 10'h000);
        check("rst_bd_out", a_bd_out, 8'h00);
        check("rst_rdata", {a_m0.rdata, a_m1.rdata}, 16'h0000);

        // 1: m0 write to W5300
        @(posedge fclk); #1;
        clear_cnt();
        exp_bd = 8'h5C;
        a_access(1'b0, 1'b1, 1'b0, 10'h3A5, 8'h5C, lat, rd);
        check("t1_latency", lat, 7);
        check("t1_addr", a_addr, 10'h3A5);
        check("t1_bd_out", a_bd_out, 8'h5C);
        repeat (3) @(posedge fclk);
        #1;
        check("t1_cs0_cycles", n_cs0, 6);
        check("t1_cs1_cycles", n_cs1, 0);
        check("t1_bwr_cycles", n_wr, 4);
        check("t1_brd_cycles", n_rd, 0);
        check("t1_oe_cycles", n_oe, 6);
        check("t1_bd_stable", n_bdbad, 0);
        check("t1_done0", n_d0, 1);
        check("t1_done1", n_d1, 0);
        check("t1_idle", {a_busy, a_oe, a_cs0_n}, 3'b001);

        // 2: m1 read from SL811
        clear_cnt();
        bd_in = 8'hA7;
        a_access(1'b1, 1'b0, 1'b1, 10'h001, 8'h00, lat, rd);
        check("t2_latency", lat, 7);
        check("t2_rdata", rd, 8'hA7);
        check("t2_a0", a_addr[0], 1'b1);
        check("t2_m0_rdata", a_m0.rdata, 8'h00);
        repeat (3) @(posedge fclk);
        #1;
        check("t2_cs1_cycles", n_cs1, 6);
        check("t2_cs0_cycles", n_cs0, 0);
        check("t2_brd_cycles", n_rd, 4);
        check("t2_oe_cycles", n_oe, 0);
        check("t2_done", {n_d0[7:0], n_d1[7:0]}, 16'h0001);

        // 3: simultaneous requests, fixed priority
        clear_cnt();
        exp_bd = 8'h11;
        bd_in  = 8'h6E;
        d0cyc = 0; d1cyc = 0;
        a_m0.we = 1'b1; a_m0.chip = 1'b1; a_m0.addr = 10'h0F0; a_m0.wdata = 8'h11;
        a_m1.we = 1'b0; a_m1.chip = 1'b0; a_m1.addr = 10'h200; a_m1.wdata = 8'h00;
        a_m0.req = 1'b1;
        a_m1.req = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge fclk); #1;
            if (a_m0.done) begin d0cyc = i; a_m0.req = 1'b0; end
            if (a_m1.done) begin d1cyc = i; a_m1.req = 1'b0; break; end
        end
        a_m0.req = 1'b0;
        a_m1.req = 1'b0;
        check("t3_m0_first", d0cyc, 7);
        check("t3_m1_second", d1cyc, 15);
        check("t3_m1_rdata", a_m1.rdata, 8'h6E);
        repeat (3) @(posedge fclk);
        #1;
        check("t3_cs_cycles", {n_cs0[7:0], n_cs1[7:0]}, 16'h0606);
        check("t3_one_cs", n_viol, 0);
        check("t3_done", {n_d0[7:0], n_d1[7:0]}, 16'h0101);
        check("t3_bd_stable", n_bdbad, 0);

        // 4: reset in the middle of a write strobe
        clear_cnt();
        exp_bd = 8'h99;
        a_m0.we = 1'b1; a_m0.chip = 1'b0; a_m0.addr = 10'h155; a_m0.wdata = 8'h99;
        a_m0.req = 1'b1;
        repeat (3) @(posedge fclk);
        #1;
        check("t4_in_strobe", {a_bwr_n, a_cs0_n, a_oe}, 3'b001);
        rst = 1'b1;
        #1;
        check("t4_rst_release", {a_bwr_n, a_brd_n, a_cs0_n, a_cs1_n, a_oe, a_busy}, 6'b111100);
        a_m0.req = 1'b0;
        #2 rst = 1'b0;
        clear_cnt();
        repeat (10) @(posedge fclk);
        #1;
        check("t4_no_done", n_d0 + n_d1, 0);
        check("t4_no_strobe", n_wr + n_rd, 0);
        clear_cnt();
        bd_in = 8'h3C;
        a_access(1'b1, 1'b0, 1'b0, 10'h2F0, 8'h00, lat, rd);
        check("t4_after_latency", lat, 7);
        check("t4_after_rdata", rd, 8'h3C);
        check("t4_after_addr", a_addr, 10'h2F0);

        // 5: 2/7/3/2 timing
        repeat (3) @(posedge fclk);
        #1;
        clear_cnt();
        bd_in = 8'h00;
        p_access(1'b0, 10'h123, 8'h00, lat);
        check("t5_latency", lat, 13);
        repeat (4) @(posedge fclk);
        #1;
        check("t5_cs_cycles", pn_cs, 12);
        check("t5_strobe_cycles", pn_str, 7);
        // Back-to-back: m1 done 15 cycles after m0 done = 12 access + 3 idle cycles.
        clear_cnt();
        d0cyc = 0; d1cyc = 0;
        p_m0.we = 1'b1; p_m0.chip = 1'b0; p_m0.addr = 10'h010; p_m0.wdata = 8'h42;
        p_m1.we = 1'b0; p_m1.chip = 1'b1; p_m1.addr = 10'h000; p_m1.wdata = 8'h00;
        p_m0.req = 1'b1;
        p_m1.req = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge fclk); #1;
            if (p_m0.done) begin d0cyc = i; p_m0.req = 1'b0; end
            if (p_m1.done) begin d1cyc = i; p_m1.req = 1'b0; break; end
        end
        p_m0.req = 1'b0;
        p_m1.req = 1'b0;
        check("t5_pair_m0", d0cyc, 13);
        check("t5_pair_m1", d1cyc, 28);
        check("t5_pair_cs", pn_cs, 24);
        check("t5_pair_strobe", pn_str, 14);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
